sumador_arbiter: RTL
====================

Name: sumador_arbiter

Overview:
- Shares one WIDTH-bit adder (instance of the team's `sumador` block) among NREQ requesters.
- Typical requesters: PC+4 increment, branch-target calculation, load/store address generation, auxiliary units.
- Arbitration is round-robin with a valid/ready handshake per requester.
- Results leave through one registered response port tagged with the requester ID, with backpressure.
- Sits between the core's control/datapath units and the shared adder.

Parameters:
- WIDTH, 32, operand and result width in bits.
- NREQ, 4, number of requesters; range 2..8.
- IDW, $clog2(NREQ), width of the requester-ID tag.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_n  input  1  asynchronous reset, active low.
- req_valid  input  NREQ  bit i: requester i presents operands.
- req_ready  output  NREQ  bit i: requester i's operands accepted this cycle; one-hot or zero.
- req_dataa  input  NREQ*WIDTH  operand A of requester i in bits [i*WIDTH +: WIDTH].
- req_datab  input  NREQ*WIDTH  operand B, same packing.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response this cycle.
- rsp_id  output  IDW  requester index that produced rsp_result.
- rsp_result  output  WIDTH  registered sum, modulo 2^WIDTH.

Behaviour:
- Reset (RST_n=0, async):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rr_ptr=0.
  - req_ready=0 while reset is asserted.
  - An in-flight response is discarded, never delivered after reset.
- accept = ~rsp_valid | rsp_ready. This is a single output stage; the slot is freed in the same cycle it is drained.
- Grant, combinational:
  - When accept=1 and any req_valid=1, grant the first valid requester scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 only for the granted index g; all other bits 0.
  - When accept=0, req_ready=0.
- A transfer occurs on a rising CLK where req_valid[g] & req_ready[g].
  - Next cycle: rsp_valid=1, rsp_id=g, rsp_result = dataa_g + datab_g (carry discarded, wrap-around).
  - rr_ptr <= (g+1) mod NREQ.
- Latency and throughput:
  - Exactly 1 cycle from transfer to rsp_valid.
  - Throughput 1 op/cycle while rsp_ready=1.
- Hold:
  - While rsp_valid=1 & rsp_ready=0, rsp_id and rsp_result are stable and no new grant is issued.
- Drain without new request: rsp_valid=1 & rsp_ready=1 & no req_valid → rsp_valid<=0 next cycle; rr_ptr unchanged.
- Simultaneous drain and transfer: output register reloads in the same edge; rsp_valid stays 1.
- Requester-side rules:
  - A requester must keep req_valid and its operands stable until req_ready is seen.
  - A requester may deassert only after the transfer.
- rr_ptr changes only on a transfer.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,NREQ-1,0 with no starvation.
- FSM (2 states, encoded by rsp_valid):
  - EMPTY→FULL on transfer.
  - FULL→EMPTY on rsp_ready with no transfer.
  - FULL→FULL on rsp_ready with transfer, or on stall.
- Operand A is muxed from the granted slice; the mux output feeds the `sumador` dataa input.
- Operand B is muxed the same way and feeds `sumador` datab.
- The adder output is registered in rsp_result.

Optional Feature:
- Macro: SUMADOR_ARB_CARRY_EN.
- Defined:
  - Adds output rsp_carry (1 bit): carry-out of the (WIDTH+1)-bit sum of the granted operands.
  - Registered with rsp_result; reset value 0; held under stall like rsp_result.
- Undefined:
  - Port rsp_carry does not exist; the carry is discarded.
  - All other behaviour identical.

Test Plan:
- Single request:
  - Stimulus: after reset, req_valid=4'b0100, A2=32'h0000_0005, B2=32'h0000_0003, rsp_ready=1.
  - Response: req_ready=4'b0100 same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_result=32'h0000_0008; rr_ptr=3.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held, operand A_i=i, B_i=100, rsp_ready=1.
  - Response: successive rsp_id 0,1,2,3,0; rsp_result 100,101,102,103,100; one result per cycle.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles after a grant to requester 1 (A=7, B=9); req_valid[3]=1 pending.
  - Response: rsp_result=16 and rsp_id=1 stable; req_ready=0 throughout.
  - When rsp_ready=1: grant 3 in that same cycle; next cycle rsp_id=3.
- Wrap-around and carry:
  - Stimulus: A0=32'hFFFF_FFFF, B0=32'h0000_0002.
  - Response: rsp_result=32'h0000_0001; with SUMADOR_ARB_CARRY_EN, rsp_carry=1.
  - Stimulus: A0=1, B0=1.
  - Response: rsp_carry=0.
- Reset mid-operation:
  - Stimulus: assert RST_n=0 asynchronously while rsp_valid=1 and rsp_ready=0.
  - Response: rsp_valid, rsp_result and rsp_id go to 0 immediately without a clock edge.
  - After release with req_valid=4'b1010: first grant goes to requester 1, since rr_ptr=0.
- Idle drain:
  - Stimulus: single transfer then req_valid=0, rsp_ready=1.
  - Response: rsp_valid high for exactly 1 cycle, then 0; rr_ptr unchanged in the idle cycle.

Source files
------------

// File: rtl/sumador_arbiter.sv
// Round-robin arbiter sharing one `sumador` adder among NREQ requesters, with a registered, ID-tagged response.
// Optional macro SUMADOR_ARB_CARRY_EN adds the registered rsp_carry output.

module sumador #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
`ifdef SUMADOR_ARB_CARRY_EN
    output logic             carry,
`endif
    output logic [WIDTH-1:0] result
);
`ifdef SUMADOR_ARB_CARRY_EN
    assign {carry, result} = {1'b0, dataa} + {1'b0, datab};
`else
    assign result = dataa + datab;
`endif
endmodule

module sumador_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dataa,
    input  logic [NREQ*WIDTH-1:0] req_datab,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
`ifdef SUMADOR_ARB_CARRY_EN
    output logic                  rsp_carry,
`endif
    output logic [WIDTH-1:0]      rsp_result
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic             found;
    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] opa, opb, sum;
`ifdef SUMADOR_ARB_CARRY_EN
    logic             sum_carry;
`endif

    assign rsp_valid = (state_q == FULL);
    assign accept    = ~rsp_valid | rsp_ready;
    assign xfer      = |req_ready;

    // First valid requester scanning from rr_ptr upward, wrapping at NREQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(rr_ptr) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (RST_n && accept && found)
            req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        opa = '0;
        opb = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                opa = req_dataa[i*WIDTH +: WIDTH];
                opb = req_datab[i*WIDTH +: WIDTH];
            end
        end
    end

    sumador #(.WIDTH(WIDTH)) u_sumador (
        .dataa  (opa),
        .datab  (opb),
`ifdef SUMADOR_ARB_CARRY_EN
        .carry  (sum_carry),
`endif
        .result (sum)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (xfer) state_d = FULL;
                     else if (rsp_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= EMPTY;
            rr_ptr     <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
`ifdef SUMADOR_ARB_CARRY_EN
            rsp_carry  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (xfer) begin
                rsp_id     <= gnt_idx;
                rsp_result <= sum;
`ifdef SUMADOR_ARB_CARRY_EN
                rsp_carry  <= sum_carry;
`endif
                rr_ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule
